// File: rtl/mc_chroma_sched_if.sv
// Handshake bundle between the encoder top controller and the chroma MC LCU scheduler.
// The slave modport is the scheduler's view; the master modport is the controller/engine side.
interface mc_chroma_sched_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic             buf_free_i;
  logic             mc_done_i;
  logic             mc_launch_o;
  logic             mc_sel_o;
  logic             buf_sel_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] cyc_cnt_o;
  logic             err_o;

  modport slave (
    input  start_i, buf_free_i, mc_done_i,
    output mc_launch_o, mc_sel_o, buf_sel_o, busy_o, done_o, cyc_cnt_o, err_o
  );

  modport master (
    output start_i, buf_free_i, mc_done_i,
    input  mc_launch_o, mc_sel_o, buf_sel_o, busy_o, done_o, cyc_cnt_o, err_o
  );
endinterface

// File: rtl/mc_chroma_sched.sv
// LCU scheduler for chroma MC: runs the engine for U then V, ping-pongs the pred bank and
// counts busy cycles. Optional run watchdog is built when MC_CHROMA_SCHED_WDT_EN is defined.
module mc_chroma_sched #(
  parameter int CNT_W     = 16,
  parameter int WDT_LIMIT = 4096
) (
  input  logic              clk,
  input  logic              rstn,
  mc_chroma_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, WAIT_BUF, LAUNCH_U, RUN_U, LAUNCH_V, RUN_V, DONE
  } state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             bank_q, bank_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             wdt_to;
  logic             running;

  assign running = (state_q == RUN_U) || (state_q == RUN_V);

`ifdef MC_CHROMA_SCHED_WDT_EN
  localparam int WDT_W = $clog2(WDT_LIMIT) + 1;
  logic [WDT_W-1:0] wdt_q, wdt_d;

  // A done in the limit cycle wins over the timeout.
  assign wdt_to = running && !bus.mc_done_i && (wdt_q == WDT_W'(WDT_LIMIT - 1));

  always_comb begin
    wdt_d = wdt_q;
    if ((state_q == LAUNCH_U) || (state_q == LAUNCH_V)) wdt_d = '0;
    else if (running)                                    wdt_d = wdt_q + WDT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) wdt_q <= '0;
    else       wdt_q <= wdt_d;
  end
`else
  logic unused_wdt_limit;
  assign unused_wdt_limit = (WDT_LIMIT == 0);
  assign wdt_to = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (bus.start_i) state_d = bus.buf_free_i ? LAUNCH_U : WAIT_BUF;
      WAIT_BUF: if (bus.buf_free_i) state_d = LAUNCH_U;
      LAUNCH_U: state_d = RUN_U;
      RUN_U:    if (bus.mc_done_i) state_d = LAUNCH_V;
                else if (wdt_to)   state_d = DONE;
      LAUNCH_V: state_d = RUN_V;
      RUN_V:    if (bus.mc_done_i || wdt_to) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d  = sel_q;
    bank_d = bank_q;
    cnt_d  = cnt_q;
    err_d  = err_q | wdt_to;
    if (state_d == LAUNCH_U) sel_d = 1'b0;
    if (state_d == LAUNCH_V) sel_d = 1'b1;
    if (state_q == DONE)     bank_d = ~bank_q;
    // Count includes the current cycle, so the DONE cycle is already in at done_o.
    if ((state_q == IDLE) && (state_d != IDLE))
      cnt_d = CNT_W'(1);
    else if ((state_q != IDLE) && (state_d != IDLE) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      bank_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      bank_q  <= bank_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.mc_launch_o = (state_q == LAUNCH_U) || (state_q == LAUNCH_V);
  assign bus.done_o      = (state_q == DONE);
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.mc_sel_o    = sel_q;
  assign bus.buf_sel_o   = bank_q;
  assign bus.cyc_cnt_o   = cnt_q;
  assign bus.err_o       = err_q;

endmodule
